// File: rtl/scsdpram_pkg.sv
// Shared definitions for the scsdpram_pipe storage core: default geometry,
// latency bound and the address-width helper functions.
package scsdpram_pkg;

    localparam int C_DEF_WIDTH      = 32;
    localparam int C_DEF_DEPTH      = 1024;
    localparam int C_DEF_LANE_WIDTH = 8;
    localparam int C_MAX_RD_LATENCY = 4;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Ceiling log2 clamped to at least one bit so a port is never zero-width.
    function automatic int clog2s(input int value);
        int result;
        result = clog2(value);
        return (result < 1) ? 1 : result;
    endfunction

    localparam int C_LANES = C_DEF_WIDTH / C_DEF_LANE_WIDTH;
    localparam int C_AW    = clog2s(C_DEF_DEPTH);

endpackage

// File: rtl/scsdpram_pipe_stage.sv
// One read-pipeline register carrying {valid, data}. Data only loads when the
// incoming beat is valid so the output holds steady between strobes.
module scsdpram_pipe_stage
    import scsdpram_pkg::*;
#(
    parameter int C_WIDTH = C_DEF_WIDTH
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               i_valid,
    input  logic [C_WIDTH-1:0] i_data,
    output logic               o_valid,
    output logic [C_WIDTH-1:0] o_data
);

    logic               r_valid;
    logic [C_WIDTH-1:0] r_data;

    // Advance the valid strobe every cycle; capture data only with a valid beat.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/scsdpram_pipe.sv
// Single-clock simple dual-port RAM with per-lane write enables, a registered
// read pipeline of configurable depth, read-during-write bypass selection and
// out-of-range address handling. Read-side state resets synchronously; the
// array itself is never reset so it maps onto block RAM.
module scsdpram_pipe
    import scsdpram_pkg::*;
#(
    parameter int C_WIDTH      = C_DEF_WIDTH,
    parameter int C_DEPTH      = C_DEF_DEPTH,
    parameter int C_LANE_WIDTH = C_DEF_LANE_WIDTH,
    parameter int C_RD_LATENCY = 1,
    parameter int C_BYPASS     = 1
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              RD1_EN,
    input  logic [clog2s(C_DEPTH)-1:0]        RD1_ADDR,
    output logic [C_WIDTH-1:0]                RD1_DATA,
    output logic                              RD1_VALID,
    input  logic                              WR1_EN,
    input  logic [clog2s(C_DEPTH)-1:0]        WR1_ADDR,
    input  logic [C_WIDTH/C_LANE_WIDTH-1:0]   WR1_BE,
    input  logic [C_WIDTH-1:0]                WR1_DATA
);

    localparam int          L_LANES = C_WIDTH / C_LANE_WIDTH;
    localparam int          L_AW    = clog2s(C_DEPTH);
    localparam logic [L_AW:0] L_DEPTH = C_DEPTH[L_AW:0];

    // Reject illegal geometries at elaboration time.
    if ((C_WIDTH % C_LANE_WIDTH) != 0) begin : g_err_lane
        $fatal(1, "scsdpram_pipe: C_WIDTH must be a multiple of C_LANE_WIDTH");
    end
    if ((C_RD_LATENCY < 1) || (C_RD_LATENCY > C_MAX_RD_LATENCY)) begin : g_err_lat
        $fatal(1, "scsdpram_pipe: C_RD_LATENCY must be within 1..4");
    end
    if (C_DEPTH < 2) begin : g_err_depth
        $fatal(1, "scsdpram_pipe: C_DEPTH must be at least 2");
    end

    logic [C_WIDTH-1:0] r_mem [0:C_DEPTH-1];

    logic               w_rd_in_range;
    logic               w_wr_in_range;
    logic               w_collide;
    logic [C_WIDTH-1:0] w_byp_mask;
    logic [C_WIDTH-1:0] w_s1_data;

    logic               r_s1_valid;
    logic               r_s1_oor;
    logic [C_WIDTH-1:0] r_s1_raw;
    logic [C_WIDTH-1:0] r_s1_byp_mask;
    logic [C_WIDTH-1:0] r_s1_byp_data;

    logic [C_RD_LATENCY-1:0]              w_pv;
    logic [C_RD_LATENCY-1:0][C_WIDTH-1:0] w_pd;

    assign w_rd_in_range = ({1'b0, RD1_ADDR} < L_DEPTH);
    assign w_wr_in_range = ({1'b0, WR1_ADDR} < L_DEPTH);
    assign w_collide     = RD1_EN && WR1_EN && w_wr_in_range &&
                           (RD1_ADDR == WR1_ADDR) && (C_BYPASS != 0);

    // Expand lane enables of a colliding write into a bit mask for the bypass merge.
    always_comb begin
        w_byp_mask = '0;
        for (int i = 0; i < L_LANES; i++) begin
            w_byp_mask[i*C_LANE_WIDTH +: C_LANE_WIDTH] = {C_LANE_WIDTH{w_collide & WR1_BE[i]}};
        end
    end

    // Lane-masked array write; out-of-range addresses and writes under reset are dropped.
    always_ff @(posedge CLK) begin
        if (!RST && WR1_EN && w_wr_in_range) begin
            for (int i = 0; i < L_LANES; i++) begin
                if (WR1_BE[i]) begin
                    r_mem[WR1_ADDR][i*C_LANE_WIDTH +: C_LANE_WIDTH] <= WR1_DATA[i*C_LANE_WIDTH +: C_LANE_WIDTH];
                end
            end
        end
    end

    // Stage 1: registered array read plus the bypass and range information needed to finish the word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s1_valid    <= 1'b0;
            r_s1_oor      <= 1'b0;
            r_s1_raw      <= '0;
            r_s1_byp_mask <= '0;
            r_s1_byp_data <= '0;
        end else begin
            r_s1_valid <= RD1_EN;
            if (RD1_EN) begin
                r_s1_oor      <= !w_rd_in_range;
                r_s1_byp_mask <= w_byp_mask;
                r_s1_byp_data <= WR1_DATA;
                if (w_rd_in_range) begin
                    r_s1_raw <= r_mem[RD1_ADDR];
                end
            end
        end
    end

    // Finish the stage-1 word: zero for out-of-range, otherwise old data with bypassed lanes overlaid.
    always_comb begin
        w_s1_data = '0;
        if (r_s1_oor) begin
            w_s1_data = '0;
        end else begin
            w_s1_data = (r_s1_raw & ~r_s1_byp_mask) | (r_s1_byp_data & r_s1_byp_mask);
        end
    end

    assign w_pv[0] = r_s1_valid;
    assign w_pd[0] = w_s1_data;

    for (genvar k = 1; k < C_RD_LATENCY; k++) begin : g_stage
        scsdpram_pipe_stage #(
            .C_WIDTH (C_WIDTH)
        ) u_stage (
            .CLK     (CLK),
            .RST     (RST),
            .i_valid (w_pv[k-1]),
            .i_data  (w_pd[k-1]),
            .o_valid (w_pv[k]),
            .o_data  (w_pd[k])
        );
    end

    assign RD1_VALID = w_pv[C_RD_LATENCY-1];
    assign RD1_DATA  = w_pd[C_RD_LATENCY-1];

endmodule

// File: tb/tb_scsdpram_pipe.sv
// Bench for scsdpram_pipe: four instances covering latencies 1..4, both bypass
// modes and a non-power-of-two depth, all driven by the same stimulus and
// compared every cycle against a cycle-scheduled reference model.
module tb_scsdpram_pipe;

    localparam int NDUT = 4;
    localparam int AW   = 10;
    localparam int MAXC = 8192;

    function automatic int lat_of(input int g);
        return g + 1;
    endfunction
    function automatic int byp_of(input int g);
        return ((g % 2) == 0) ? 1 : 0;
    endfunction
    function automatic int dep_of(input int g);
        return ((g == 0) || (g == 3)) ? 1000 : 1024;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          re  = 1'b0;
    logic [AW-1:0] ra  = '0;
    logic          we  = 1'b0;
    logic [AW-1:0] wa  = '0;
    logic [3:0]    be  = 4'h0;
    logic [31:0]   wd  = 32'h0;

    logic [31:0] rd_data  [NDUT];
    logic        rd_valid [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        scsdpram_pipe #(
            .C_WIDTH      (32),
            .C_DEPTH      (dep_of(g)),
            .C_LANE_WIDTH (8),
            .C_RD_LATENCY (lat_of(g)),
            .C_BYPASS     (byp_of(g))
        ) u_dut (
            .CLK       (clk),
            .RST       (rst),
            .RD1_EN    (re),
            .RD1_ADDR  (ra),
            .RD1_DATA  (rd_data[g]),
            .RD1_VALID (rd_valid[g]),
            .WR1_EN    (we),
            .WR1_ADDR  (wa),
            .WR1_BE    (be),
            .WR1_DATA  (wd)
        );
    end

    // Reference model: word store per instance and a table of results keyed by the cycle they appear.
    logic [31:0] mmem   [NDUT][1024];
    bit          sv     [NDUT][MAXC];
    logic [31:0] sd     [NDUT][MAXC];
    logic [31:0] last_d [NDUT];
    logic        exp_v  [NDUT];
    logic [31:0] exp_d  [NDUT];
    int          cyc    = 0;
    int          n_vec  = 0;
    int          n_err  = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                                input logic [3:0] m);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    // One clock: update the model with the inputs present at the edge, then check every instance.
    task automatic tick();
        logic [31:0] d;
        @(posedge clk);
        cyc++;
        for (int g = 0; g < NDUT; g++) begin
            if (rst) begin
                for (int k = 0; k < 5; k++) sv[g][cyc+k] = 1'b0;
                last_d[g] = 32'h0;
            end else begin
                if (re) begin
                    if (int'(ra) >= dep_of(g)) begin
                        d = 32'h0;
                    end else begin
                        d = mmem[g][ra];
                        if ((byp_of(g) == 1) && we && (wa == ra)) d = merge_lanes(d, wd, be);
                    end
                    sv[g][cyc+lat_of(g)-1] = 1'b1;
                    sd[g][cyc+lat_of(g)-1] = d;
                end
                if (we && (int'(wa) < dep_of(g))) mmem[g][wa] = merge_lanes(mmem[g][wa], wd, be);
            end
            if (sv[g][cyc]) begin
                exp_v[g]  = 1'b1;
                exp_d[g]  = sd[g][cyc];
                last_d[g] = sd[g][cyc];
            end else begin
                exp_v[g] = 1'b0;
                exp_d[g] = last_d[g];
            end
        end
        #1;
        for (int g = 0; g < NDUT; g++) begin
            check_val($sformatf("valid[L%0d]@%0d", lat_of(g), cyc), {31'b0, rd_valid[g]}, {31'b0, exp_v[g]});
            check_val($sformatf("data[L%0d]@%0d", lat_of(g), cyc), rd_data[g], exp_d[g]);
        end
    endtask

    // Apply the read already set up on the inputs, then confirm the strobe lands exactly L cycles later.
    task automatic observe(input string tag, input logic [31:0] e_byp, input logic [31:0] e_nobyp);
        for (int t = 0; t < 4; t++) begin
            tick();
            if (t == 0) begin
                re = 1'b0;
                we = 1'b0;
            end
            for (int g = 0; g < NDUT; g++) begin
                if (t == lat_of(g) - 1) begin
                    check_val($sformatf("%s_valid[L%0d]", tag, lat_of(g)), {31'b0, rd_valid[g]}, 32'd1);
                    check_val($sformatf("%s_data[L%0d]", tag, lat_of(g)), rd_data[g],
                              (byp_of(g) == 1) ? e_byp : e_nobyp);
                end else if (t < lat_of(g) - 1) begin
                    check_val($sformatf("%s_early[L%0d]", tag, lat_of(g)), {31'b0, rd_valid[g]}, 32'd0);
                end
            end
        end
    endtask

    function automatic logic [AW-1:0] pick_addr();
        if ($urandom_range(0, 3) == 0) return AW'(990 + $urandom_range(0, 33));
        return AW'($urandom_range(0, 15));
    endfunction

    logic [31:0] keep;

    initial begin
        // Reset held with reads requested: nothing may come out.
        rst = 1'b1; re = 1'b1; ra = 10'd3;
        repeat (3) tick();
        rst = 1'b0; re = 1'b0;
        tick();

        // Fill every location so later reads never touch unwritten words.
        for (int a = 0; a < 1024; a++) begin
            we = 1'b1; wa = AW'(a); be = 4'hF; wd = $urandom;
            tick();
        end
        we = 1'b0;

        // Partial-lane overwrite.
        we = 1'b1; wa = 10'd5; be = 4'hF; wd = 32'hDEADBEEF; tick();
        wa = 10'd5; be = 4'h1; wd = 32'h000000AA; tick();
        we = 1'b0; re = 1'b1; ra = 10'd5;
        observe("lanes", 32'hDEADBEAA, 32'hDEADBEAA);

        // Read-during-write collision.
        we = 1'b1; wa = 10'd7; be = 4'hF; wd = 32'h11111111; tick();
        re = 1'b1; ra = 10'd7; we = 1'b1; wa = 10'd7; be = 4'h3; wd = 32'h22222222;
        observe("collide", 32'h11112222, 32'h11111111);
        re = 1'b1; ra = 10'd7;
        observe("after_collide", 32'h11112222, 32'h11112222);

        // Back-to-back reads with writes chasing them through the pipeline.
        for (int i = 0; i < 20; i++) begin
            re = (i < 16); ra = AW'(i % 16);
            we = (i >= 1) && (i <= 16); wa = AW'((i + 15) % 16); be = 4'hF; wd = $urandom;
            tick();
        end
        re = 1'b0; we = 1'b0;
        repeat (4) tick();

        // Out-of-range write and read on the 1000-deep instances.
        keep = mmem[0][10];
        we = 1'b1; wa = 10'd1010; be = 4'hF; wd = 32'hCAFEF00D; tick();
        we = 1'b0; re = 1'b1; ra = 10'd1010; tick();
        ra = 10'd10; tick();
        re = 1'b0;
        repeat (4) tick();
        check_val("addr10_kept", mmem[3][10], keep);

        // Reset with reads in flight at several phases, then a clean read.
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k <= j; k++) begin
                re = 1'b1; ra = AW'($urandom_range(0, 15)); tick();
            end
            rst = 1'b1; re = 1'b1;
            repeat (2) tick();
            rst = 1'b0; re = 1'b0;
            tick();
            re = 1'b1; ra = 10'd5; keep = mmem[1][5];
            observe($sformatf("post_rst%0d", j), keep, keep);
        end

        // Randomised traffic including collisions, partial lanes, out-of-range and resets.
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            re  = $urandom_range(0, 1);
            ra  = pick_addr();
            we  = $urandom_range(0, 1);
            wa  = ($urandom_range(0, 2) == 0) ? ra : pick_addr();
            be  = 4'($urandom_range(0, 15));
            wd  = $urandom;
            tick();
        end
        rst = 1'b0; re = 1'b0; we = 1'b0;
        repeat (6) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
